unidad_deteccion_riesgos: RTL and testbench

UNIDAD_DETECCION_RIESGOS -- requirements
Module: unidad_deteccion_riesgos

---
 rtl/unidad_deteccion_riesgos_pkg.sv | 20 ++
 rtl/unidad_deteccion_riesgos_registro_ex_mem.sv | 55 +++++
 rtl/unidad_deteccion_riesgos.sv | 158 +++++++++++++++
 tb/tb_unidad_deteccion_riesgos.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/unidad_deteccion_riesgos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkg_riesgos
//  Description : Shared types and defaults for the hazard-detection unit.
//                estado_t : FSM encoding (RUN = normal flow,
//                           ESPERA = waiting for the data-memory ack)
//                REG_W_DEF: default register-index width
//  Revision    : 1.0 - initial release
// ============================================================================
package pkg_riesgos;

    localparam int REG_W_DEF = 4;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        ESPERA = 1'b1
    } estado_t;

endpackage : pkg_riesgos
`default_nettype wire

// File: rtl/unidad_deteccion_riesgos_registro_ex_mem.sv
`default_nettype none
// ============================================================================
//  Module      : registro_ex_mem
//  Description : EX/MEM pipeline slice holding the destination register and
//                the "valid load" flag of the instruction in MEM.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                enable_i      - capture new EX values (low = hold)
//                clr_load_i    - drop the pending load (memory timeout)
//                rd_i          - EX destination register
//                load_i        - EX instruction is a valid load
//                rl_o          - MEM destination register
//                load_o        - MEM instruction is a valid load
//  Revision    : 1.0 - initial release
// ============================================================================
module registro_ex_mem
    import pkg_riesgos::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             clr_load_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic             load_i,
    output logic [REG_W-1:0] rl_o,
    output logic             load_o
);

    logic [REG_W-1:0] rl_q;
    logic             load_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rl_q   <= '0;
            load_q <= 1'b0;
        end else begin
            if (enable_i) begin
                rl_q <= rd_i;
            end
            // A timed-out load is abandoned even though the stage is held,
            // so the clear wins over the hold.
            if (clr_load_i) begin
                load_q <= 1'b0;
            end else if (enable_i) begin
                load_q <= load_i;
            end
        end
    end

    assign rl_o   = rl_q;
    assign load_o = load_q;

endmodule : registro_ex_mem
`default_nettype wire

// File: rtl/unidad_deteccion_riesgos.sv
`default_nettype none
// ============================================================================
//  Module      : unidad_deteccion_riesgos
//  Description : Pipeline hazard-detection unit. Detects load-use hazards
//                between EX and ID, stalls the pipeline while a MEM-stage
//                load waits for the data memory, and flags a sticky error
//                when the memory does not answer within MEM_TIMEOUT cycles.
//  Ports       : clk, rst                    - clock, sync active-high reset
//                valid_ex, load_ex, rd_ex    - EX instruction info
//                ra_id, rb_id                - ID source registers
//                usa_a_id, usa_b_id          - ID reads ra_id / rb_id
//                mem_ack                     - data memory finished the load
//                rl, load                    - MEM-stage dest / valid load
//                mem_req                     - load request to data memory
//                stall_if, stall_id, stall_ex- pipeline holds
//                burbuja_ex                  - inject NOP into EX
//                mem_error                   - sticky timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module unidad_deteccion_riesgos
    import pkg_riesgos::*;
#(
    parameter int REG_W       = REG_W_DEF,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_ex,
    input  logic             load_ex,
    input  logic [REG_W-1:0] rd_ex,
    input  logic [REG_W-1:0] ra_id,
    input  logic [REG_W-1:0] rb_id,
    input  logic             usa_a_id,
    input  logic             usa_b_id,
    input  logic             mem_ack,
    output logic [REG_W-1:0] rl,
    output logic             load,
    output logic             mem_req,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             burbuja_ex,
    output logic             mem_error
);

    localparam int               c_CNT_W   = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ULT = c_CNT_W'(MEM_TIMEOUT - 1);

    estado_t            estado_q, estado_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               mem_error_q, mem_error_d;
    logic               haz;
    logic               timeout;

    // ------------------------------------------------------------------
    // Load-use hazard: register 0 is hard-wired, so it never conflicts.
    // ------------------------------------------------------------------
    assign haz = valid_ex & load_ex & (rd_ex != '0) &
                 ((usa_a_id & (ra_id == rd_ex)) | (usa_b_id & (rb_id == rd_ex)));

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    registro_ex_mem #(
        .REG_W (REG_W)
    ) u_registro_ex_mem (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (~stall_ex),
        .clr_load_i (timeout),
        .rd_i       (rd_ex),
        .load_i     (load_ex & valid_ex),
        .rl_o       (rl),
        .load_o     (load)
    );

    // ------------------------------------------------------------------
    // FSM state, wait counter and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= RUN;
            cnt_q       <= '0;
            mem_error_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        mem_error_d = mem_error_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        burbuja_ex  = 1'b0;
        timeout     = 1'b0;

        unique case (estado_q)
            RUN: begin
                // A pending memory load outranks a load-use bubble.
                if (load && !mem_ack) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    cnt_d    = '0;
                    estado_d = ESPERA;
                end else if (haz) begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    burbuja_ex = 1'b1;
                end
            end
            ESPERA: begin
                if (mem_ack) begin
                    // Ack wins over a coinciding timeout.
                    cnt_d    = '0;
                    estado_d = RUN;
                end else if (cnt_q == c_CNT_ULT) begin
                    stall_if    = 1'b1;
                    stall_id    = 1'b1;
                    stall_ex    = 1'b1;
                    timeout     = 1'b1;
                    mem_error_d = 1'b1;
                    cnt_d       = '0;
                    estado_d    = RUN;
                end else begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    // Saturating guard; the timeout clears long before.
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                estado_d = RUN;
            end
        endcase

        // Outputs are quiet while reset is asserted.
        if (rst) begin
            stall_if   = 1'b0;
            stall_id   = 1'b0;
            stall_ex   = 1'b0;
            burbuja_ex = 1'b0;
        end
    end

    assign mem_req   = load & ~rst;
    assign mem_error = mem_error_q;

endmodule : unidad_deteccion_riesgos
`default_nettype wire

// File: tb/tb_unidad_deteccion_riesgos.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unidad_deteccion_riesgos
//  Description : Self-checking bench for unidad_deteccion_riesgos. One record
//                per clock cycle: inputs driven after the falling edge, the
//                expected outputs queued and compared shortly afterwards.
//                Expected field order: {rl, load, mem_req, stall_if,
//                stall_id, stall_ex, burbuja_ex, mem_error}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unidad_deteccion_riesgos;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_ex, load_ex;
    logic [3:0] rd_ex, ra_id, rb_id;
    logic       usa_a_id, usa_b_id, mem_ack;
    logic [3:0] rl;
    logic       load, mem_req, stall_if, stall_id, stall_ex, burbuja_ex, mem_error;

    always #5 clk = ~clk;

    unidad_deteccion_riesgos #(
        .REG_W       (4),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_ex   (valid_ex),
        .load_ex    (load_ex),
        .rd_ex      (rd_ex),
        .ra_id      (ra_id),
        .rb_id      (rb_id),
        .usa_a_id   (usa_a_id),
        .usa_b_id   (usa_b_id),
        .mem_ack    (mem_ack),
        .rl         (rl),
        .load       (load),
        .mem_req    (mem_req),
        .stall_if   (stall_if),
        .stall_id   (stall_id),
        .stall_ex   (stall_ex),
        .burbuja_ex (burbuja_ex),
        .mem_error  (mem_error)
    );

    typedef struct {
        logic        rst, valid_ex, load_ex;
        logic [3:0]  rd_ex, ra_id, rb_id;
        logic        usa_a_id, usa_b_id, mem_ack;
        logic [10:0] exp;
    } vec_t;

    vec_t        tabla[$];
    logic [10:0] sb[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          idx_to = -1;

    task automatic add(input logic r, v, l, input logic [3:0] rd, ra, rb,
                       input logic ua, ub, ack,
                       input logic [3:0] erl, input logic eld, emr, esi, esd,
                       esx, ebu, eme);
        vec_t t;
        t.rst = r; t.valid_ex = v; t.load_ex = l;
        t.rd_ex = rd; t.ra_id = ra; t.rb_id = rb;
        t.usa_a_id = ua; t.usa_b_id = ub; t.mem_ack = ack;
        t.exp = {erl, eld, emr, esi, esd, esx, ebu, eme};
        tabla.push_back(t);
    endtask

    task automatic chk(input string nombre, input logic ok);
        n_vec++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: rl=%0d load=%b mem_req=%b stall_if/id/ex=%b%b%b burbuja_ex=%b mem_error=%b",
                     nombre, rl, load, mem_req, stall_if, stall_id, stall_ex, burbuja_ex, mem_error);
        end
    endtask

    task automatic aplicar(input int k);
        logic [10:0] act, exp;
        @(negedge clk);
        rst      = tabla[k].rst;
        valid_ex = tabla[k].valid_ex;
        load_ex  = tabla[k].load_ex;
        rd_ex    = tabla[k].rd_ex;
        ra_id    = tabla[k].ra_id;
        rb_id    = tabla[k].rb_id;
        usa_a_id = tabla[k].usa_a_id;
        usa_b_id = tabla[k].usa_b_id;
        mem_ack  = tabla[k].mem_ack;
        sb.push_back(tabla[k].exp);
        #1;
        exp = sb.pop_front();
        act = {rl, load, mem_req, stall_if, stall_id, stall_ex, burbuja_ex, mem_error};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d: got rl=%0d load=%b mem_req=%b stall_if/id/ex=%b%b%b burbuja_ex=%b mem_error=%b; want rl=%0d load=%b mem_req=%b stall_if/id/ex=%b%b%b burbuja_ex=%b mem_error=%b",
                     k, act[10:7], act[6], act[5], act[4], act[3], act[2], act[1], act[0],
                     exp[10:7], exp[6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        rst = 1'b1; valid_ex = 0; load_ex = 0; rd_ex = 0; ra_id = 0; rb_id = 0;
        usa_a_id = 0; usa_b_id = 0; mem_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", (rl === 4'd0) && (load === 1'b0) && (mem_req === 1'b0) &&
                           (stall_if === 1'b0) && (stall_id === 1'b0) &&
                           (stall_ex === 1'b0) && (burbuja_ex === 1'b0) &&
                           (mem_error === 1'b0));

        //   r v l rd ra rb ua ub ak | rl ld mr si sd sx bu me
        add(1,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0); // reset state
        add(0,1,1, 7, 7, 0, 1, 0, 0,   0, 0, 0, 1, 1, 0, 1, 0); // load-use ra
        add(0,0,0, 0, 0, 0, 0, 0, 1,   7, 1, 1, 0, 0, 0, 0, 0); // rl=7 load=1
        add(0,1,1, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0); // r0: no hazard
        add(0,0,0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0, 0, 0, 0);
        add(0,1,1, 5, 3, 5, 1, 1, 0,   0, 0, 0, 1, 1, 0, 1, 0); // load-use rb
        add(0,1,0, 2, 2, 0, 1, 0, 1,   5, 1, 1, 0, 0, 0, 0, 0); // not a load
        add(0,1,1, 9, 9, 1, 0, 1, 0,   2, 0, 0, 0, 0, 0, 0, 0); // usa_a_id=0
        // Delayed ack with a simultaneous load-use hazard: memory stall wins.
        for (int i = 0; i < 3; i++)
            add(0,1,1, 4, 4, 0, 1, 0, 0,   9, 1, 1, 1, 1, 1, 0, 0);
        add(0,1,0, 6, 0, 0, 0, 0, 1,   9, 1, 1, 0, 0, 0, 0, 0); // ack cycle
        add(0,1,1, 3, 3, 0, 1, 0, 0,   6, 0, 0, 1, 1, 0, 1, 0); // back in RUN

        // Hand-written: ack arrives exactly at the timeout count.
        for (int i = 0; i < 15; i++)
            add(0,0,0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 1, 1, 1, 0, 0);
        add(0,1,1, 3, 0, 0, 0, 0, 1,   3, 1, 1, 0, 0, 0, 0, 0);
        // Hand-written: full timeout (1 RUN cycle + 15 wait cycles).
        for (int i = 0; i < 16; i++)
            add(0,0,0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 1, 1, 1, 0, 0);
        idx_to = tabla.size();
        add(0,0,0, 0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 1); // error, load dropped
        add(0,1,1, 2, 2, 0, 1, 0, 0,   0, 0, 0, 1, 1, 0, 1, 1); // sticky
        add(0,0,0, 0, 0, 0, 0, 0, 1,   2, 1, 1, 0, 0, 0, 0, 1);
        // Hand-written: reset while waiting in ESPERA.
        add(0,1,1,10, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1);
        add(0,0,0, 0, 0, 0, 0, 0, 0,  10, 1, 1, 1, 1, 1, 0, 1);
        add(0,0,0, 0, 0, 0, 0, 0, 0,  10, 1, 1, 1, 1, 1, 0, 1);
        add(1,0,0, 0, 0, 0, 0, 0, 0,  10, 1, 0, 0, 0, 0, 0, 1); // outputs quiet
        add(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        add(0,1,1, 7, 7, 0, 1, 0, 0,   0, 0, 0, 1, 1, 0, 1, 0); // RUN again
        add(0,0,0, 0, 0, 0, 0, 0, 0,   7, 1, 1, 1, 1, 1, 0, 0);
        add(0,0,0, 0, 0, 0, 0, 0, 1,   7, 1, 1, 0, 0, 0, 0, 0);
        add(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);

        foreach (tabla[k]) begin
            aplicar(k);
            if (k == idx_to)
                chk("expired wait", (mem_error === 1'b1) && (load === 1'b0) &&
                                    (mem_req === 1'b0) && (stall_ex === 1'b0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_unidad_deteccion_riesgos
`default_nettype wire
